// File: rtl/bridge_mem_pkg.sv
// Types shared by the bridge-to-memory responder: FSM states, posted-write FIFO entry,
// and the byte-reversal helper used when BRIDGE_MEM_BYTESWAP_EN is defined.
package bridge_mem_pkg;

  localparam int WORD_ADDR_W = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } bridge_state_e;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] word_addr;
    logic [31:0]            data;
  } fifo_entry_t;

  function automatic logic [31:0] byte_swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/bridge_mem_fifo.sv
// Synchronous write-posting FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate counter.
module bridge_mem_fifo
  import bridge_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  fifo_entry_t    slots_q [DEPTH];

  always_comb begin
    full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
            (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    count = wr_ptr_q - rd_ptr_q;
    head  = slots_q[rd_ptr_q[PTR_W-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which slots hold live data.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      slots_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
    end
  end

endmodule

// File: rtl/bridge_mem_responder.sv
// Bridge leaf responder: posts writes through a FIFO, issues reads only after earlier
// writes drain. Define BRIDGE_MEM_BYTESWAP_EN to byte-reverse data in both directions.
module bridge_mem_responder
  import bridge_mem_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 18,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               bridge_addr,
  input  logic                      bridge_wr,
  input  logic [31:0]               bridge_wr_data,
  input  logic                      bridge_rd,
  output logic [31:0]               bridge_rd_data,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wr_data,
  output logic                      mem_wr,
  output logic                      mem_rd,
  input  logic                      mem_ready,
  input  logic                      mem_rd_valid,
  input  logic [31:0]               mem_rd_data,
  output logic                      overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  bridge_state_e             state_q, state_d;
  logic                      pend_q, pend_d;
  logic [MEM_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]               rd_data_q, rd_data_d;
  logic                      overflow_q, overflow_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, fifo_count_next;
  fifo_entry_t      push_entry, fifo_head;
  logic [31:0]      wr_data_mem, rd_data_bridge;
  logic             unused_bits;

`ifdef BRIDGE_MEM_BYTESWAP_EN
  assign wr_data_mem    = byte_swap32(bridge_wr_data);
  assign rd_data_bridge = byte_swap32(mem_rd_data);
`else
  assign wr_data_mem    = bridge_wr_data;
  assign rd_data_bridge = mem_rd_data;
`endif

  assign push_entry.word_addr = bridge_addr[31:2];
  assign push_entry.data      = wr_data_mem;
  assign unused_bits = ^{bridge_addr[1:0], fifo_head.word_addr[WORD_ADDR_W-1:MEM_ADDR_WIDTH]};

  bridge_mem_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_comb begin
    fifo_push       = bridge_wr && !fifo_full;
    fifo_pop        = (state_q == DRAIN) && mem_ready && !fifo_empty;
    // Occupancy after this edge lets a write accepted now reach the bus next cycle.
    fifo_count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q || (bridge_wr && fifo_full);

    if (bridge_rd && !pend_q) begin
      pend_d      = 1'b1;
      pend_addr_d = bridge_addr[MEM_ADDR_WIDTH+1:2];
    end

    unique case (state_q)
      IDLE, DRAIN: begin
        if (fifo_count_next != '0) begin
          state_d = DRAIN;
        end else if (pend_d) begin
          state_d = RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (mem_ready) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_rd_valid) begin
          state_d   = IDLE;
          pend_d    = 1'b0;
          rd_data_d = rd_data_bridge;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_wr         = (state_q == DRAIN);
    mem_rd         = (state_q == RD_REQ);
    mem_addr       = '0;
    mem_wr_data    = '0;
    bridge_rd_data = rd_data_q;
    overflow       = overflow_q;
    if (state_q == DRAIN) begin
      mem_addr    = fifo_head.word_addr[MEM_ADDR_WIDTH-1:0];
      mem_wr_data = fifo_head.data;
    end else if (state_q == RD_REQ) begin
      mem_addr = pend_addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_bridge_mem_responder.sv
// Randomised bench for bridge_mem_responder: a queue-based bus model predicts every output
// each cycle, and a memory responder in the bench answers writes and reads.
module tb_bridge_mem_responder;

  localparam int MAW   = 18;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [31:0]    bridge_addr = '0;
  logic           bridge_wr = 1'b0;
  logic [31:0]    bridge_wr_data = '0;
  logic           bridge_rd = 1'b0;
  logic [31:0]    bridge_rd_data;
  logic [MAW-1:0] mem_addr;
  logic [31:0]    mem_wr_data;
  logic           mem_wr, mem_rd;
  logic           mem_ready = 1'b0;
  logic           mem_rd_valid = 1'b0;
  logic [31:0]    mem_rd_data = '0;
  logic           overflow;

  int vectors = 0;
  int miscompares = 0;

  bridge_mem_responder #(.MEM_ADDR_WIDTH(MAW), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .bridge_addr    (bridge_addr),
    .bridge_wr      (bridge_wr),
    .bridge_wr_data (bridge_wr_data),
    .bridge_rd      (bridge_rd),
    .bridge_rd_data (bridge_rd_data),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr         (mem_wr),
    .mem_rd         (mem_rd),
    .mem_ready      (mem_ready),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_side(input logic [31:0] d);
`ifdef BRIDGE_MEM_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // ---------------- behavioural model: what the memory bus is doing ----------------
  typedef enum int {B_IDLE, B_WR, B_RD, B_WAIT} bus_e;
  typedef struct {
    logic [MAW-1:0] a;
    logic [31:0]    d;
  } ent_t;

  ent_t           q[$];
  bus_e           bus = B_IDLE;
  bit             rpend = 1'b0;
  logic [MAW-1:0] raddr = '0;
  logic [31:0]    rdata = '0;
  bit             ovf = 1'b0;

  // Memory responder state, shared with the driver loop below.
  logic [31:0] memory [int unsigned];
  int          resp_cnt = -1;
  logic [31:0] resp_data = '0;
  int          ready_mode = 1;
  int          resp_dmin = 0;
  int          resp_dmax = 0;

  always @(negedge clk) begin
    logic [31:0] e_addr, e_wdata;
    bus_e        cur;
    bit          full_now;
    ent_t        e;
    if (reset) begin
      q.delete();
      bus = B_IDLE; rpend = 1'b0; raddr = '0; rdata = '0; ovf = 1'b0;
    end
    e_addr = '0;
    e_wdata = '0;
    if (bus == B_WR) begin
      e_addr  = 32'(q[0].a);
      e_wdata = q[0].d;
    end else if (bus == B_RD) begin
      e_addr = 32'(raddr);
    end
    chk("mem_wr", 32'(mem_wr), 32'(bus == B_WR));
    chk("mem_rd", 32'(mem_rd), 32'(bus == B_RD));
    chk("mem_addr", 32'(mem_addr), e_addr);
    chk("mem_wr_data", mem_wr_data, e_wdata);
    chk("bridge_rd_data", bridge_rd_data, rdata);
    chk("overflow", 32'(overflow), 32'(ovf));

    if (!reset) begin
      cur = bus;
      full_now = (q.size() == DEPTH);
      if (cur == B_WR && mem_ready) void'(q.pop_front());
      if (bridge_wr) begin
        if (full_now) begin
          ovf = 1'b1;
        end else begin
          e.a = bridge_addr[MAW+1:2];
          e.d = mem_side(bridge_wr_data);
          q.push_back(e);
        end
      end
      if (bridge_rd && !rpend) begin
        rpend = 1'b1;
        raddr = bridge_addr[MAW+1:2];
      end
      case (cur)
        B_RD:    if (mem_ready) bus = B_WAIT;
        B_WAIT:  if (mem_rd_valid) begin
                   rdata = mem_side(mem_rd_data);
                   rpend = 1'b0;
                   bus = B_IDLE;
                 end
        default: bus = (q.size() > 0) ? B_WR : (rpend ? B_RD : B_IDLE);
      endcase
    end

    // Environment: memory contents and read-return scheduling.
    if (mem_wr && mem_ready) memory[32'(mem_addr)] = mem_wr_data;
    if (mem_rd && mem_ready) begin
      resp_cnt  = int'($urandom_range(resp_dmax, resp_dmin));
      resp_data = memory.exists(32'(mem_addr)) ? memory[32'(mem_addr)] : 32'h0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       mem_ready = 1'b0;
        1:       mem_ready = 1'b1;
        default: mem_ready = ($urandom_range(9, 0) < 7);
      endcase
      mem_rd_valid = 1'b0;
      mem_rd_data  = $urandom;
      if (resp_cnt == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = resp_data;
        resp_cnt     = -1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
      end
    end
  end

  task automatic cyc(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    bridge_wr      = wr;
    bridge_rd      = rd;
    bridge_addr    = addr;
    bridge_wr_data = data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk("reset_bridge_rd_data", bridge_rd_data, 32'h0);
    chk("reset_mem_wr_rd", 32'({mem_wr, mem_rd}), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Single posted write with memory always ready.
    cyc(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("wr_mem_wr", 32'(mem_wr), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h4);
`ifdef BRIDGE_MEM_BYTESWAP_EN
    chk("wr_mem_wr_data", mem_wr_data, 32'hEFBE_ADDE);
`else
    chk("wr_mem_wr_data", mem_wr_data, 32'hDEAD_BEEF);
`endif
    idle(4);

`ifdef BRIDGE_MEM_BYTESWAP_EN
    cyc(1'b1, 1'b0, 32'h0000_0014, 32'h1122_3344);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("swap_mem_wr_data", mem_wr_data, 32'h4433_2211);
    idle(4);
`endif

    // Same-cycle write and read of one address: write goes out first.
    cyc(1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("wr_then_rd_c1_wr", 32'({mem_wr, mem_rd}), 32'h2);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("wr_then_rd_c2_rd", 32'({mem_wr, mem_rd}), 32'h1);
    chk("wr_then_rd_c2_addr", 32'(mem_addr), 32'h2);
    idle(2);
    @(negedge clk);
    chk("wr_then_rd_data", bridge_rd_data, 32'h1234_5678);
    idle(3);

    // Read latency with empty FIFO and zero-wait memory.
    cyc(1'b1, 1'b0, 32'h0000_0020, 32'hA5A5_0F0F);
    idle(4);
    cyc(1'b0, 1'b1, 32'h0000_0020, 32'h0);
    idle(2);
    @(negedge clk);
    chk("latency_c2_old", bridge_rd_data, 32'h1234_5678);
    idle(1);
    @(negedge clk);
    chk("latency_c3_new", bridge_rd_data, 32'hA5A5_0F0F);
    idle(2);

    // Five writes with memory stalled: four buffered, fifth dropped.
    ready_mode = 0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_head_addr", 32'(mem_addr), 32'h40);
`ifdef BRIDGE_MEM_BYTESWAP_EN
    chk("ovf_head_data", mem_wr_data, 32'h0000_DEC0);
`else
    chk("ovf_head_data", mem_wr_data, 32'hC0DE_0000);
`endif
    ready_mode = 2;
    idle(12);
    ready_mode = 1;
    idle(2);

    // Reset while a read is waiting for data; the late return must be ignored.
    resp_dmin = 5;
    resp_dmax = 5;
    cyc(1'b0, 1'b1, 32'h0000_0008, 32'h0);
    idle(2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_rdwait_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_rdwait_rd_data", bridge_rd_data, 32'h0);
    chk("rst_rdwait_overflow", 32'(overflow), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(8);
    @(negedge clk);
    chk("rst_late_valid_ignored", bridge_rd_data, 32'h0);
    idle(2);

    // Randomised traffic against the model.
    resp_dmin = 0;
    resp_dmax = 3;
    ready_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      a = ($urandom_range(1, 0) == 1) ? ($urandom & 32'hFFF0_003F) : $urandom;
      cyc($urandom_range(9, 0) < 3, $urandom_range(99, 0) < 12, a, $urandom);
    end
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bridge_mem_responder.md
BRIDGE_MEM_RESPONDER -- requirements
Module: bridge_mem_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 18, meaning memory-side word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning write-posting FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  bridge clock; the block's only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bridge_addr  input  32  leaf-local byte address from the bridge master.
REQ-006 SHALL have port bridge_wr  input  1  single-cycle write strobe.
REQ-007 SHALL have port bridge_wr_data  input  32  write data, valid with bridge_wr.
REQ-008 SHALL have port bridge_rd  input  1  single-cycle read strobe.
REQ-009 SHALL have port bridge_rd_data  output  32  read data, held until the next read completes.
REQ-010 SHALL have port mem_addr  output  MEM_ADDR_WIDTH  word address, equal to bridge_addr[MEM_ADDR_WIDTH+1:2].
REQ-011 SHALL have port mem_wr_data  output  32  memory write data.
REQ-012 SHALL have port mem_wr / mem_rd  output  1 each  request strobes, held until mem_ready.
REQ-013 SHALL have port mem_ready  input  1  request accepted this cycle.
REQ-014 SHALL have port mem_rd_valid / mem_rd_data  input  1 / 32  read return.
REQ-015 SHALL have port overflow  output  1  sticky: a write was dropped.

Function
REQ-016 SHALL push {word address, data} into the FIFO on each bridge_wr while the FIFO is not full, with zero-cycle acceptance.
REQ-017 SHALL drop a bridge_wr arriving while the FIFO is full and set overflow; overflow SHALL be cleared only by reset.
REQ-018 SHALL use FSM states IDLE, DRAIN, RD_REQ, RD_WAIT; IDLE->DRAIN when FIFO non-empty; DRAIN presents the FIFO head with mem_wr=1 and pops on mem_ready.
REQ-019 SHALL latch the read address on bridge_rd into a pending register; reads SHALL be issued only after every earlier write has been popped (write-before-read ordering).
REQ-020 SHALL move from DRAIN or IDLE to RD_REQ when a read is pending and the FIFO is empty; RD_REQ holds mem_rd=1 until mem_ready, then RD_WAIT.
REQ-021 SHALL capture mem_rd_data into bridge_rd_data on mem_rd_valid in RD_WAIT and return to IDLE; end-to-end latency SHALL be 3 cycles from bridge_rd with an empty FIFO and zero-wait memory.
REQ-022 SHALL, on a bridge_wr and bridge_rd in the same cycle, push the write first, so the read returns the new data.
REQ-023 SHALL ignore a second bridge_rd while a read is pending (the first read address is kept).
REQ-024 SHALL never assert mem_wr and mem_rd together; FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty flagged by an extra pointer bit.

Reset
REQ-025 SHALL on reset force state IDLE, FIFO empty, pending cleared, mem_wr=mem_rd=0, mem_addr=0, mem_wr_data=0, bridge_rd_data=0, overflow=0; a transaction cut off mid-flight by reset SHALL be abandoned.

Configuration
REQ-026 SHALL, with BRIDGE_MEM_BYTESWAP_EN defined, byte-reverse 32-bit data in both directions (bridge big-endian to little-endian memory); without it, data SHALL pass unchanged.

Structure
REQ-027 SHALL place the FSM state enum and the FIFO entry struct in package bridge_mem_pkg.
REQ-028 SHALL implement the write buffer as sub-module bridge_mem_fifo (synchronous FIFO with push/pop/full/empty).

Verification
REQ-029 SHALL cover: write 0x00000010<-0xDEADBEEF with mem_ready tied 1 -> mem_wr at mem_addr 0x4, data 0xDEADBEEF one cycle later.
REQ-030 SHALL cover: 5 back-to-back writes with mem_ready=0 and FIFO_DEPTH=4 -> first four buffered, fifth dropped, overflow=1.
REQ-031 SHALL cover: write 0x8<-0x12345678 and read 0x8 in the same cycle -> mem_wr precedes mem_rd; bridge_rd_data=0x12345678.
REQ-032 SHALL cover: BRIDGE_MEM_BYTESWAP_EN defined, write 0x11223344 -> mem_wr_data=0x44332211.
REQ-033 SHALL cover: reset asserted in RD_WAIT -> outputs zero next cycle; a later mem_rd_valid is ignored.
